// File: rtl/fb_rect_writer.sv
// Rectangle-fill write engine for framebuffer port A, one pixel per clock in raster order.
// Build option: define FB_RECT_CLIP_EN to clip rectangles to the screen instead of rejecting them.
module fb_rect_writer #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17,
    parameter int RGB_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [8:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [8:0]        cmd_w,
    input  logic [7:0]        cmd_h,
    input  logic [RGB_W-1:0]  cmd_rgb,
    output logic [ADDR_W-1:0] addr_A,
    output logic [RGB_W-1:0]  dataIn_A,
    output logic              wren_A,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // state    | meaning
    // S_IDLE   | ready for a command
    // S_DRAW   | one pixel write per cycle
    // S_DONE   | completion pulse, back to idle
    // S_REJECT | out-of-range command refused (unclipped build only)
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAW   = 2'd1,
        S_DONE   = 2'd2,
        S_REJECT = 2'd3
    } state_t;

    localparam logic [9:0]        H_LIM    = 10'(H_RES);
    localparam logic [9:0]        V_LIM    = 10'(V_RES);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

    state_t state_q, state_d;

    logic [9:0]        col_q, col_d;
    logic [9:0]        row_q, row_d;
    logic [9:0]        x0_q, x0_d;
    logic [9:0]        x_end_q, x_end_d;
    logic [9:0]        y_end_q, y_end_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic              wren_q, wren_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;

    logic       accept;
    logic       last_pix;
    logic       cmd_empty;
    logic       cmd_reject;
    logic [9:0] x_ext, y_ext;
    logic [9:0] x_end_raw, y_end_raw;
    logic [9:0] x_end_c, y_end_c;
    logic [9:0] col_inc, row_inc;

    assign accept    = cmd_valid && ready_q;
    assign x_ext     = {1'b0, cmd_x};
    assign y_ext     = {2'b00, cmd_y};
    assign x_end_raw = x_ext + {1'b0, cmd_w};
    assign y_end_raw = y_ext + {2'b00, cmd_h};
    assign col_inc   = col_q + 10'd1;
    assign row_inc   = row_q + 10'd1;
    assign last_pix  = (col_inc == x_end_q) && (row_inc == y_end_q);

`ifdef FB_RECT_CLIP_EN
    // Clamped end also makes an off-screen origin come out empty.
    assign x_end_c    = (x_end_raw > H_LIM) ? H_LIM : x_end_raw;
    assign y_end_c    = (y_end_raw > V_LIM) ? V_LIM : y_end_raw;
    assign cmd_empty  = (x_ext >= x_end_c) || (y_ext >= y_end_c);
    assign cmd_reject = 1'b0;
`else
    assign x_end_c    = x_end_raw;
    assign y_end_c    = y_end_raw;
    assign cmd_empty  = (cmd_w == 9'd0) || (cmd_h == 8'd0);
    assign cmd_reject = (x_end_raw > H_LIM) || (y_end_raw > V_LIM);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_reject) begin
                        state_d = S_REJECT;
                    end else if (cmd_empty) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAW;
                    end
                end
            end
            S_DRAW: begin
                if (last_pix) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:   state_d = S_IDLE;
            S_REJECT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        x0_d    = x0_q;
        x_end_d = x_end_q;
        y_end_d = y_end_q;
        base_d  = base_q;
        addr_d  = addr_q;
        rgb_d   = rgb_q;
        wren_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ready_d = ready_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    col_d   = x_ext;
                    row_d   = y_ext;
                    x0_d    = x_ext;
                    x_end_d = x_end_c;
                    y_end_d = y_end_c;
                    // Constant multiply, done once per command; the raster walk below only adds.
                    base_d  = ADDR_W'(cmd_y) * ROW_STEP;
                    rgb_d   = cmd_rgb;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            S_DRAW: begin
                wren_d = 1'b1;
                addr_d = base_q + ADDR_W'(col_q);
                if (col_inc == x_end_q) begin
                    col_d  = x0_q;
                    row_d  = row_inc;
                    base_d = base_q + ROW_STEP;
                end else begin
                    col_d = col_inc;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            S_REJECT: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            x0_q    <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            rgb_q   <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            x0_q    <= x0_d;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            rgb_q   <= rgb_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign addr_A    = addr_q;
    assign dataIn_A  = rgb_q;
    assign wren_A    = wren_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
